menu_overlay_reader: RTL

MENU_OVERLAY_READER -- requirements
Module: menu_overlay_reader

---
 rtl/menu_overlay_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/menu_overlay_reader.sv
// Menu overlay line reader: fetches one pixel row of a 32x32 character text
// screen from the menu RAM into a 32-byte line buffer, and answers per-pixel
// foreground lookups from that buffer with one cycle of latency.
module menu_overlay_reader #(
    parameter logic [10:0] FONT_BASE = 11'h400,
    parameter int          COLS      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    output logic        busy,
    output logic        line_ready,
    input  logic        pix_req,
    input  logic [7:0]  pix_x,
    output logic        pix_valid,
    output logic        pix_on,
    output logic        mem_ce,
    output logic [10:0] mem_addr,
    input  logic [7:0]  mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHAR  = 2'd1,
        FONT  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_col;
    logic [4:0]  w_col_nxt;
    logic [4:0]  r_row;
    logic [2:0]  r_grow;
    logic        r_inv;
    logic        r_line_ready;
    logic        w_line_ready_nxt;
    logic [7:0]  r_buf [COLS];
    logic        r_pix_vld_p1;
    logic        r_pix_on_p1;

    logic        w_mem_ce;
    logic [10:0] w_mem_addr;
    logic [10:0] w_font_addr;
    logic        w_store;
    logic [7:0]  w_store_data;

    // Glyph row address for the character code arriving from the RAM this cycle.
    assign w_font_addr  = FONT_BASE + {1'b0, mem_dout[6:0], r_grow};
    // Bit 7 of the character code selects inverse video for the whole cell.
    assign w_store_data = mem_dout ^ {8{r_inv}};

    // Next-state, column advance and RAM read-port drive for the fetch sequence.
    always_comb begin
        w_state_nxt      = r_state;
        w_col_nxt        = r_col;
        w_line_ready_nxt = r_line_ready;
        w_mem_ce         = 1'b0;
        w_mem_addr       = 11'd0;
        w_store          = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            CHAR: begin
                w_mem_ce    = 1'b1;
                w_mem_addr  = {1'b0, r_row, r_col};
                w_state_nxt = FONT;
            end
            FONT: begin
                w_mem_ce    = 1'b1;
                w_mem_addr  = w_font_addr;
                w_state_nxt = STORE;
            end
            STORE: begin
                w_store = 1'b1;
                if (r_col == 5'(COLS - 1)) begin
                    w_state_nxt      = IDLE;
                    w_line_ready_nxt = 1'b1;
                end else begin
                    w_col_nxt   = r_col + 5'd1;
                    w_state_nxt = CHAR;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A new request always wins: the running fetch is dropped, including
        // a store that would have landed this cycle.
        if (line_start) begin
            w_state_nxt      = CHAR;
            w_col_nxt        = 5'd0;
            w_line_ready_nxt = 1'b0;
            w_store          = 1'b0;
        end
    end

    assign mem_ce     = w_mem_ce;
    assign mem_addr   = w_mem_addr;
    assign busy       = (r_state != IDLE);
    assign line_ready = r_line_ready;

    // Fetch control state: FSM, column counter, latched row and inverse flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_col        <= 5'd0;
            r_row        <= 5'd0;
            r_grow       <= 3'd0;
            r_inv        <= 1'b0;
            r_line_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_line_ready <= w_line_ready_nxt;
            if (line_start) begin
                r_row  <= line_y[7:3];
                r_grow <= line_y[2:0];
            end
            if (r_state == FONT) begin
                r_inv <= mem_dout[7];
            end
        end
    end

    // Line buffer: one glyph byte per character column, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < COLS; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_store) begin
            r_buf[r_col] <= w_store_data;
        end
    end

    // ---- pixel lookup stage p0 -> p1 ----
    // Pixel lookup: read-before-write against the buffer, zero when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_vld_p1 <= 1'b0;
            r_pix_on_p1  <= 1'b0;
        end else begin
            r_pix_vld_p1 <= pix_req;
            r_pix_on_p1  <= pix_req & r_buf[pix_x[7:3]][pix_x[2:0]];
        end
    end

    assign pix_valid = r_pix_vld_p1;
    assign pix_on    = r_pix_on_p1;

endmodule
